// File: rtl/mem_addr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_addr_bus_arbiter : registered PC/data arbiter for one memory address bus
// Optional: MEM_ARB_FAIR_EN enables alternating priority on ties.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_addr_bus_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_req,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_ack,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  data_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_en,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  bus_owner,
  output logic                  busy,
  output logic                  err
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0]      ST_IDLE   = 2'd0;
  localparam logic [1:0]      ST_ACCESS = 2'd1;
  localparam logic [1:0]      ST_RESP   = 2'd2;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  we_q,    we_d;
  logic                  owner_q, owner_d;
  logic [3:0]            wait_q,  wait_d;
  logic [TO_W-1:0]       to_q,    to_d;
  logic                  err_q,   err_d;
  logic                  pick_data;

`ifdef MEM_ARB_FAIR_EN
  logic last_owner_q, last_owner_d;

  // On a tie the requester that did not own the previous access wins.
  assign pick_data = data_req && (!pc_req || !last_owner_q);

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE && (data_req || pc_req)) last_owner_d = pick_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_owner_q <= 1'b0;
    else        last_owner_q <= last_owner_d;
  end
`else
  assign pick_data = data_req;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    to_d    = to_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (data_req || pc_req) begin
          state_d = ST_ACCESS;
          owner_d = pick_data;
          addr_d  = pick_data ? data_addr : pc_addr;
          we_d    = pick_data & data_we;
          wait_d  = WAIT_INIT;
          to_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        // Completion is checked first so it beats a coincident timeout.
        if (wait_q == 4'd0 && mem_ready) begin
          state_d = ST_RESP;
        end else if (to_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      wait_q  <= 4'd0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign mem_en       = (state_q == ST_ACCESS);
  assign mem_we       = we_q & mem_en;
  assign mem_addr_out = addr_q;
  assign bus_owner    = owner_q;
  assign busy         = (state_q != ST_IDLE);
  assign pc_ack       = (state_q == ST_RESP) & ~owner_q;
  assign data_ack     = (state_q == ST_RESP) &  owner_q;
  assign err          = (state_q == ST_RESP) &  err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_addr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_addr_bus_arbiter : randomized scoreboard bench for the bus arbiter
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_addr_bus_arbiter;

  localparam int AW = 16;
  localparam int WS = 1;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_req = 1'b0, data_req = 1'b0, data_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] pc_addr = '0, data_addr = '0;
  wire           pc_ack, data_ack, mem_en, mem_we, bus_owner, busy, err;
  wire  [AW-1:0] mem_addr_out;

  mem_addr_bus_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_req(pc_req), .pc_addr(pc_addr), .pc_ack(pc_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_ack(data_ack),
    .mem_addr_out(mem_addr_out), .mem_en(mem_en), .mem_we(mem_we), .mem_ready(mem_ready),
    .bus_owner(bus_owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic          we;
    logic          err;
    int            ack_cyc;
  } txn_t;

  txn_t grant_q[$];
  txn_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference model: an access completes on the first access cycle k with
  // k > WS and mem_ready high; otherwise it aborts with err at k == TO.
  // The ack follows one cycle later and one idle cycle precedes the next grant.
  initial begin : model
    int   phase;
    int   k;
    logic last;
    logic win;
    txn_t cur;
    phase = 0; k = 0; last = 1'b0;
    cur = '{owner: 1'b0, addr: '0, we: 1'b0, err: 1'b0, ack_cyc: 0};
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        phase = 0; k = 0; last = 1'b0;
        grant_q.delete();
        exp_q.delete();
      end else begin
        case (phase)
          0: if (data_req || pc_req) begin
`ifdef MEM_ARB_FAIR_EN
            win = (data_req && pc_req) ? !last : data_req;
`else
            win = data_req;
`endif
            last        = win;
            cur.owner   = win;
            cur.addr    = win ? data_addr : pc_addr;
            cur.we      = win && data_we;
            cur.err     = 1'b0;
            cur.ack_cyc = 0;
            grant_q.push_back(cur);
            phase = 1;
            k     = 0;
          end
          1: begin
            k++;
            if (k > WS && mem_ready) begin
              cur.err = 1'b0; cur.ack_cyc = cyc + 1; exp_q.push_back(cur); phase = 2;
            end else if (k == TO) begin
              cur.err = 1'b1; cur.ack_cyc = cyc + 1; exp_q.push_back(cur); phase = 2;
            end
          end
          default: phase = 0;
        endcase
      end
      cyc++;
    end
  end

  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_en) begin
          if (grant_q.size() == 0) chk("mem_en_unexpected", {63'd0, mem_en}, 64'd0);
          else chk("access_bus", {mem_addr_out, mem_we, bus_owner, busy},
                   {grant_q[0].addr, grant_q[0].we, grant_q[0].owner, 1'b1});
        end
        if (pc_ack || data_ack) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", {62'd0, pc_ack, data_ack}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            if (grant_q.size() != 0) void'(grant_q.pop_front());
            chk("resp_flags", {pc_ack, data_ack, err, mem_en, mem_we, busy},
                {!e.owner, e.owner, e.err, 1'b0, 1'b0, 1'b1});
            chk("resp_addr", {48'd0, mem_addr_out}, {48'd0, e.addr});
            chk("ack_cycle", cyc, e.ack_cyc);
          end
        end else if (err) begin
          chk("err_without_ack", {63'd0, err}, 64'd0);
        end
      end
    end
  end

  initial begin : stim
    int  gap_d, gap_p, thr;
    bit  got;
    gap_d = 0; gap_p = 0; thr = 10;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {mem_en, mem_we, pc_ack, data_ack, busy, err, bus_owner, mem_addr_out}, '0);
    rst_n = 1'b1;

    // Directed PC fetch with mem_ready tied high.
    @(negedge clk);
    pc_req = 1'b1; pc_addr = 16'h0100; mem_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pc_ack) begin got = 1'b1; pc_req = 1'b0; end
    end
    chk("pc_fetch_ack_seen", {63'd0, got}, 64'd1);

    // Directed STR.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h3FFE;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (data_ack) begin got = 1'b1; data_req = 1'b0; end
    end
    chk("str_ack_seen", {63'd0, got}, 64'd1);

    // Randomized traffic with varying memory readiness.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 10;
          1: thr = 6;
          2: thr = 2;
          default: thr = 0;
        endcase
      end
      mem_ready = ($urandom_range(0, 9) < thr);
      if (data_req && data_ack) begin
        data_req = 1'b0; gap_d = $urandom_range(0, 3);
      end else if (!data_req) begin
        if (gap_d > 0) gap_d--;
        else if ($urandom_range(0, 3) != 0) begin
          data_req = 1'b1; data_we = $urandom_range(0, 1); data_addr = AW'($urandom);
        end
      end else if (!busy && $urandom_range(0, 3) == 0) begin
        data_addr = AW'($urandom); data_we = $urandom_range(0, 1);
      end
      if (pc_req && pc_ack) begin
        pc_req = 1'b0; gap_p = $urandom_range(0, 3);
      end else if (!pc_req) begin
        if (gap_p > 0) gap_p--;
        else if ($urandom_range(0, 3) != 0) begin
          pc_req = 1'b1; pc_addr = AW'($urandom);
        end
      end else if (!busy && $urandom_range(0, 3) == 0) begin
        pc_addr = AW'($urandom);
      end
    end

    // Drain outstanding requests.
    mem_ready = 1'b1;
    for (int i = 0; i < 100 && (pc_req || data_req || busy); i++) begin
      @(negedge clk);
      if (data_ack) data_req = 1'b0;
      if (pc_ack)   pc_req   = 1'b0;
    end
    chk("drain_idle", {61'd0, pc_req, data_req, busy}, 64'd0);
    chk("queues_empty", exp_q.size() + grant_q.size(), 0);

    // Reset in the middle of a data access.
    @(negedge clk);
    mem_ready = 1'b0; data_req = 1'b1; data_we = 1'b0; data_addr = 16'h00A5;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = mem_en;
    end
    chk("reset_test_access_started", {63'd0, got}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_access", {mem_en, busy, data_ack, pc_ack, err, mem_addr_out}, '0);
    data_req = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("after_reset_idle", {61'd0, busy, data_ack, mem_en}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_addr_bus_arbiter.md
Name: mem_addr_bus_arbiter

Overview:
- Registered, parametrised successor to the combinational LDR/STR-vs-PC address select.
- Arbitrates one memory address bus between two requesters: the instruction fetch port (PC) and the data port (LDR/STR).
- Adds req/ack handshakes, configurable wait states, a memory-ready handshake and a timeout.
- Sits between the control unit / register bank and the memory interface.

Parameters:
ADDR_WIDTH, 16, width of all address buses
WAIT_STATES, 1, minimum cycles in ACCESS before mem_ready is honoured (0..15)
TIMEOUT, 64, ACCESS cycles without completion before abort (must be > WAIT_STATES)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
pc_req  input  1  fetch request; held until pc_ack
pc_addr  input  ADDR_WIDTH  fetch address
pc_ack  output  1  one-cycle fetch-complete pulse
data_req  input  1  data request (LDR or STR); held until data_ack
data_we  input  1  1 = STR, 0 = LDR
data_addr  input  ADDR_WIDTH  data address from the register bank
data_ack  output  1  one-cycle data-complete pulse
mem_addr_out  output  ADDR_WIDTH  registered address to memory
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_ready  input  1  memory completion handshake
bus_owner  output  1  0 = PC, 1 = data; valid while busy
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse, coincident with ack, on a timed-out access

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low. While rst_n = 0 at a clock edge:
  - state goes to IDLE;
  - all outputs go to 0, including mem_addr_out;
  - wait and timeout counters clear.
  - Reset mid-access abandons the access with no ack.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - mem_en = 0; mem_addr_out holds its last value.
  - Priority: data_req over pc_req (default, see Optional Feature).
  - On grant, register the winner's address into mem_addr_out, the winner's we into mem_we (0 for PC), and bus_owner.
  - Load the wait counter with WAIT_STATES and the timeout counter with 0, then go to ACCESS.
- ACCESS:
  - mem_en = 1; address and we stay stable for the whole access.
  - Wait counter decrements to 0; the timeout counter increments every cycle.
  - Completion: wait counter == 0 and mem_ready == 1 → RESP.
  - Timeout: timeout counter reaches TIMEOUT-1 without completion → RESP with the err flag set.
  - mem_ready while the wait counter is nonzero is ignored.
- RESP:
  - mem_en = 0, mem_we = 0.
  - Exactly one of pc_ack / data_ack = 1, selected by bus_owner; err = 1 if the access timed out.
  - Next state is IDLE unconditionally.
- Latency: request sampled in IDLE at cycle t.
  - mem_en is high from t+1.
  - With mem_ready tied high, ack appears at t+WAIT_STATES+2.
  - Back-to-back accesses have a minimum period of WAIT_STATES+3 cycles.
- Handshake rules:
  - A requester must drop req in the cycle after it sees ack. A req still high in IDLE is a new request.
  - Changes to an address while its req is pending but not yet granted are allowed; the value is sampled at grant.
  - Requests are only sampled in IDLE.
- Simultaneous events:
  - Both reqs high in IDLE → data wins (default); the PC stays pending.
  - mem_ready and the timeout on the same cycle → completion wins, err = 0.
- Width rule: addresses pass unmodified at ADDR_WIDTH; no wrap or offset arithmetic.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- When defined: alternating priority. A 1-bit last_owner register resets to 0 (PC), so the first tie goes to data. When both reqs are high in IDLE, the requester that did not own the previous access wins. A single request is granted regardless.
- When undefined: fixed data-over-PC priority, and the last_owner logic is not present.

Test Plan:
- Reset: drive rst_n = 0 mid-ACCESS with data_req = 1, data_addr = 16'h00A5 → next cycle mem_en = 0, busy = 0, mem_addr_out = 16'h0000, no data_ack.
- PC fetch: WAIT_STATES = 1, pc_req = 1, pc_addr = 16'h0100, mem_ready = 1 → mem_en high for cycles t+1 and t+2, mem_addr_out = 16'h0100, mem_we = 0, pc_ack pulse at t+3.
- STR: data_req = 1, data_we = 1, data_addr = 16'h3FFE → mem_we = 1 during ACCESS, bus_owner = 1, data_ack pulse, pc_ack stays 0.
- Contention:
  - Without the macro: pc_req and data_req both held high → data granted every time it requests; the PC is granted only once data_req drops.
  - With MEM_ARB_FAIR_EN: grants alternate data, PC, data, PC.
- Late ready: mem_ready = 0 for 5 cycles, then 1 → ack 5 cycles later than nominal, err = 0; mem_ready pulsed while the wait counter is nonzero is ignored.
- Timeout: TIMEOUT = 8, mem_ready held 0 → ACCESS lasts 8 cycles, then ack and err pulse together for one cycle, then IDLE.
